// File: rtl/cpu_bus_memory_if.sv
// CPU data-bus bundle between the core (master) and the data-side memory (slave).
interface cpu_bus_memory_if #(
  parameter int unsigned DATA_W = 32
);
  logic              CS;
  logic              WR;
  logic [31:0]       ADDR;
  logic [DATA_W-1:0] Data_BUS_WRITE;
  logic [DATA_W-1:0] Data_BUS_READ;
  logic              RD_VALID;
  logic              OOR_ERR;
  logic [15:0]       WR_COUNT;
  logic [15:0]       RD_COUNT;
  logic              CLR_STATS;

  modport master (
    output CS, WR, ADDR, Data_BUS_WRITE, CLR_STATS,
    input  Data_BUS_READ, RD_VALID, OOR_ERR, WR_COUNT, RD_COUNT
  );

  modport slave (
    input  CS, WR, ADDR, Data_BUS_WRITE, CLR_STATS,
    output Data_BUS_READ, RD_VALID, OOR_ERR, WR_COUNT, RD_COUNT
  );
endinterface

// File: rtl/cpu_bus_memory.sv
// Word-addressed data memory for the CPU data bus: written-word tracking,
// out-of-range/misalignment flag, saturating access counters, 0..4 cycle reads.
module cpu_bus_memory #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned ADDR_SHIFT   = 2,
  parameter int unsigned READ_LAT     = 1,
  parameter logic [31:0] DEFAULT_DATA = 32'h0000_1DAA
) (
  input logic             CLK,
  input logic             RST,
  cpu_bus_memory_if.slave bus
);
  localparam int unsigned       IDX_W    = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] DEF_WORD = DATA_W'(DEFAULT_DATA);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  wvalid_r;
  logic [15:0]       wr_cnt_r;
  logic [15:0]       rd_cnt_r;
  logic              oor_err_r;

  logic [31:0]       off_s;
  logic [31:0]       idx_full_s;
  logic [31:0]       align_mask_s;
  logic [IDX_W-1:0]  idx_s;
  logic              in_range_s;
  logic              rd_req_s;
  logic              wr_req_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              rd_valid_s;
  logic [DATA_W-1:0] rd_data_s;

  // Address decode and the word a read would return if sampled this cycle.
  always_comb begin
    off_s        = bus.ADDR - BASE_ADDR;
    idx_full_s   = off_s >> ADDR_SHIFT;
    align_mask_s = (32'd1 << ADDR_SHIFT) - 32'd1;
    idx_s        = idx_full_s[IDX_W-1:0];
    in_range_s   = (bus.ADDR >= BASE_ADDR) && (idx_full_s < 32'(DEPTH)) &&
                   ((off_s & align_mask_s) == 32'd0);
    rd_req_s     = bus.CS & ~bus.WR;
    wr_req_s     = bus.CS & bus.WR;
    if (in_range_s && wvalid_r[idx_s]) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = DEF_WORD;
    end
  end

  // Storage array; deliberately not reset, validity lives in wvalid_r.
  always_ff @(posedge CLK) begin
    if (wr_req_s && in_range_s) begin
      mem_r[idx_s] <= bus.Data_BUS_WRITE;
    end
  end

  // Per-word written tracking.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wvalid_r <= {DEPTH{1'b0}};
    end else if (wr_req_s && in_range_s) begin
      wvalid_r[idx_s] <= 1'b1;
    end
  end

  // Statistics: clear wins over counting; counters stick at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_cnt_r  <= 16'd0;
      rd_cnt_r  <= 16'd0;
      oor_err_r <= 1'b0;
    end else if (bus.CLR_STATS) begin
      wr_cnt_r  <= 16'd0;
      rd_cnt_r  <= 16'd0;
      oor_err_r <= 1'b0;
    end else if (bus.CS) begin
      if (bus.WR && (wr_cnt_r != 16'hFFFF)) begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
      if (!bus.WR && (rd_cnt_r != 16'hFFFF)) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
      if (!in_range_s) begin
        oor_err_r <= 1'b1;
      end
    end
  end

  if (READ_LAT == 0) begin : g_comb
    logic [DATA_W-1:0] last_r;

    // Remembers the last read result so the bus holds it between reads.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        last_r <= DEF_WORD;
      end else if (rd_req_s) begin
        last_r <= rd_word_s;
      end
    end

    // Same-cycle read path; suppressed while reset is asserted.
    always_comb begin
      rd_valid_s = rd_req_s & RST;
      if (rd_valid_s) begin
        rd_data_s = rd_word_s;
      end else begin
        rd_data_s = last_r;
      end
    end
  end else begin : g_pipe
    logic [READ_LAT-1:0] vld_r;
    logic [DATA_W-1:0]   dat_r [READ_LAT];

    // Data captured at request time, so a later write cannot alter a read in flight.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        vld_r <= {READ_LAT{1'b0}};
        for (int i = 0; i < READ_LAT; i++) begin
          dat_r[i] <= DEF_WORD;
        end
      end else begin
        vld_r[0] <= rd_req_s;
        if (rd_req_s) begin
          dat_r[0] <= rd_word_s;
        end
        for (int i = 1; i < READ_LAT; i++) begin
          vld_r[i] <= vld_r[i-1];
          if (vld_r[i-1]) begin
            dat_r[i] <= dat_r[i-1];
          end
        end
      end
    end

    always_comb begin
      rd_valid_s = vld_r[READ_LAT-1];
      rd_data_s  = dat_r[READ_LAT-1];
    end
  end

  assign bus.Data_BUS_READ = rd_data_s;
  assign bus.RD_VALID      = rd_valid_s;
  assign bus.OOR_ERR       = oor_err_r;
  assign bus.WR_COUNT      = wr_cnt_r;
  assign bus.RD_COUNT      = rd_cnt_r;
endmodule

// File: tb/tb_cpu_bus_memory.sv
// Scoreboard bench: one shared stimulus drives four memories with READ_LAT 0..3.
module tb_cpu_bus_memory;
  localparam logic [31:0] DEF = 32'h0000_1DAA;
  localparam int NI = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs    = 1'b0;
  logic        wr    = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        rdv   [NI];
  logic [31:0] rdd   [NI];
  logic        oor_o [NI];
  logic [15:0] wrc   [NI];
  logic [15:0] rdc   [NI];

  logic [63:0] exp_q  [NI][$];
  logic [31:0] last_m [NI];
  logic [31:0] mem_m  [256];
  logic        wv_m   [256];
  logic [15:0] wr_m = 16'd0;
  logic [15:0] rd_m = 16'd0;
  logic        oor_m = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cpu_bus_memory_if #(.DATA_W(32)) bus ();
    assign bus.CS             = cs;
    assign bus.WR             = wr;
    assign bus.ADDR           = addr;
    assign bus.Data_BUS_WRITE = wdata;
    assign bus.CLR_STATS      = clr;
    assign rdv[g]   = bus.RD_VALID;
    assign rdd[g]   = bus.Data_BUS_READ;
    assign oor_o[g] = bus.OOR_ERR;
    assign wrc[g]   = bus.WR_COUNT;
    assign rdc[g]   = bus.RD_COUNT;
    cpu_bus_memory #(.READ_LAT(g)) u_dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus.slave)
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every falling edge: each instance must show exactly the scheduled result,
  // and hold its last delivered value otherwise.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic        ev;
      logic [31:0] ed;
      ev = 1'b0;
      ed = last_m[k];
      if (exp_q[k].size() > 0) begin
        if (int'(exp_q[k][0][63:32]) + k == cyc) begin
          ev = 1'b1;
          ed = exp_q[k][0][31:0];
          void'(exp_q[k].pop_front());
          last_m[k] = ed;
        end
      end
      chk($sformatf("lat%0d_valid", k), {31'd0, rdv[k]}, {31'd0, ev});
      chk($sformatf("lat%0d_data", k), rdd[k], ed);
    end
  end

  task automatic do_cycle(input logic c, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic cl);
    logic        inr;
    int          idx;
    logic [31:0] rv;
    cs = c; wr = w; addr = a; wdata = d; clr = cl;
    inr = (a[1:0] == 2'b00) && (a < 32'd1024);
    idx = int'((a >> 2) & 32'h0000_00FF);
    if (rst_n) begin
      if (c && !w) begin
        rv = (inr && wv_m[idx]) ? mem_m[idx] : DEF;
        for (int k = 0; k < NI; k++) exp_q[k].push_back({32'(cyc), rv});
      end
      if (cl) begin
        wr_m = 16'd0; rd_m = 16'd0; oor_m = 1'b0;
      end else if (c) begin
        if (w && wr_m != 16'hFFFF) wr_m = wr_m + 16'd1;
        if (!w && rd_m != 16'hFFFF) rd_m = rd_m + 16'd1;
        if (!inr) oor_m = 1'b1;
      end
      if (c && w && inr) begin
        mem_m[idx] = d;
        wv_m[idx]  = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic apply_reset(input int ncyc);
    cs = 1'b0; wr = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      last_m[k] = DEF;
    end
    for (int i = 0; i < 256; i++) wv_m[i] = 1'b0;
    wr_m = 16'd0; rd_m = 16'd0; oor_m = 1'b0;
    repeat (ncyc) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic check_stats(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_wrcnt_l%0d", tag, k), {16'd0, wrc[k]}, {16'd0, wr_m});
      chk($sformatf("%s_rdcnt_l%0d", tag, k), {16'd0, rdc[k]}, {16'd0, rd_m});
      chk($sformatf("%s_oor_l%0d", tag, k), {31'd0, oor_o[k]}, {31'd0, oor_m});
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic        rw;
    for (int k = 0; k < NI; k++) last_m[k] = DEF;
    for (int i = 0; i < 256; i++) begin
      wv_m[i]  = 1'b0;
      mem_m[i] = 32'd0;
    end

    // Reset held for 100 ns, then an unwritten read.
    apply_reset(10);
    check_stats("reset");
    do_cycle(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);

    // Simple write then read.
    do_cycle(1'b1, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h08, 32'd0, 1'b0);
    idle(4);
    check_stats("wr_rd");

    // Preload and back-to-back reads.
    do_cycle(1'b1, 1'b1, 32'h0, 32'd1, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h4, 32'd2, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h8, 32'd3, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h4, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
    idle(5);

    // Read issued just before a write to the same word keeps the old value.
    do_cycle(1'b1, 1'b0, 32'h0C, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h0C, 32'h0000_00CC, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h0C, 32'd0, 1'b0);
    idle(5);

    // Out-of-range write, misaligned reads, check no aliasing onto word 0.
    do_cycle(1'b1, 1'b1, 32'h400, 32'hBAD0_BAD0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h402, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h000, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h006, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h3FC, 32'd0, 1'b0);
    idle(5);
    check_stats("oor");

    // Clear together with a write: stats zero, word still written.
    do_cycle(1'b1, 1'b1, 32'h0, 32'hCAFE_F00D, 1'b1);
    check_stats("clr");
    do_cycle(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
    idle(5);
    check_stats("after_clr");

    // Random mix of reads, writes, clears and bad addresses.
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) ra = 32'($urandom_range(0, 1100));
      else ra = 32'($urandom_range(0, 263)) << 2;
      rw = 1'($urandom_range(0, 1));
      do_cycle(1'($urandom_range(0, 3) != 0), rw, ra, $urandom(),
               1'($urandom_range(0, 47) == 0));
    end
    idle(5);
    check_stats("random");

    // Read counter saturation.
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    repeat (65537) do_cycle(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
    idle(5);
    check_stats("sat");
    chk("sat_rd_all_ones", {16'd0, rdc[1]}, 32'h0000_FFFF);

    // Reset while reads are in flight; written word forgotten afterwards.
    do_cycle(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    apply_reset(3);
    check_stats("rst_mid");
    idle(4);
    do_cycle(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    idle(5);
    check_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_bus_memory.md
# cpu_bus_memory

Parametrised data-memory responder for the CPU data bus (CLK, RST, CS, WR, ADDR, Data_BUS_WRITE, Data_BUS_READ). It replaces a fixed constant on Data_BUS_READ with a real word-addressed RAM that has:
- configurable width, depth, base address and read latency;
- per-word "written" tracking;
- out-of-range and misaligned detection;
- saturating access statistics.

It sits beside the cpu in simulation tops and FPGA builds as the data-side memory.

## Interface
Parameters:
- DATA_W, 32, data bus width in bits.
- DEPTH, 256, number of words; power of two, 2..65536.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- ADDR_SHIFT, 2, log2 of bytes per word; low ADDR_SHIFT bits of ADDR must be zero.
- READ_LAT, 1, read latency in cycles, 0..4.
- DEFAULT_DATA, 32'h0000_1DAA, value returned for unwritten, out-of-range or misaligned reads; truncated or zero-extended to DATA_W.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  reset, asynchronous and active-low (0 = reset).
- CS  in  1  access strobe; one access per cycle where CS=1.
- WR  in  1  1 = write, 0 = read; meaningful only when CS=1.
- ADDR  in  32  byte address.
- Data_BUS_WRITE  in  DATA_W  write data.
- Data_BUS_READ  out  DATA_W  read data.
- RD_VALID  out  1  Data_BUS_READ carries the result of a read this cycle.
- OOR_ERR  out  1  sticky flag: an out-of-range or misaligned access occurred.
- WR_COUNT  out  16  accepted writes, saturating.
- RD_COUNT  out  16  accepted reads, saturating.
- CLR_STATS  in  1  synchronous clear of WR_COUNT, RD_COUNT and OOR_ERR.

## Operation
Address decode:
- off = ADDR - BASE_ADDR; idx = off >> ADDR_SHIFT.
- Access is in-range when all hold: ADDR >= BASE_ADDR, idx < DEPTH, off[ADDR_SHIFT-1:0] == 0.
- Any other access is OOR.

Write (CS=1, WR=1):
- In-range: mem[idx] <= Data_BUS_WRITE; wvalid[idx] <= 1.
- OOR: memory untouched; OOR_ERR <= 1.
- WR_COUNT increments in both cases.

Read (CS=1, WR=0):
- Result = mem[idx] if in-range and wvalid[idx]=1; otherwise DEFAULT_DATA.
- OOR read also sets OOR_ERR.
- RD_COUNT increments.

Memory state:
- Memory array is not reset.
- wvalid[DEPTH-1:0] clears on reset, so every word reads DEFAULT_DATA until first written.

Counters and flags:
- Counters hold at 16'hFFFF once reached; no wrap.
- CLR_STATS=1 has priority: counters <= 0 and OOR_ERR <= 0. An access in the same cycle is still performed on memory but neither counted nor flagged.

Reset (RST=0, at any time including mid-pipeline):
- Data_BUS_READ = DEFAULT_DATA; RD_VALID = 0; OOR_ERR = 0; WR_COUNT = 0; RD_COUNT = 0.
- All wvalid bits and read-pipeline stages cleared; in-flight reads are dropped.

## Timing
Read, READ_LAT = L >= 1:
- Read sampled at edge n. Data_BUS_READ and RD_VALID are registered and present after edge n+L-1, i.e. visible in cycle n+L relative to the request cycle.
- Back-to-back reads are fully pipelined: one result per cycle, in order.

Read, READ_LAT = 0:
- Data_BUS_READ and RD_VALID are combinational from CS/WR/ADDR in the request cycle.
- When no read result is presented, Data_BUS_READ holds its last read value (L=0: last registered value) and RD_VALID = 0.

Write-then-read ordering:
- Write at edge n followed by a read of the same address sampled at edge n+1 or later returns the new data; no bypass is needed since one access occurs per cycle.
- A read issued before a write to the same address returns the old data even if it is still in the pipeline when the write lands; capture happens at request time.

Flags and counters:
- OOR_ERR and the counters update at the same edge that samples the access; no latency parameter applies.
- CS=0: no state change except pipeline advance.

## Test plan
- Reset: hold RST=0 for 100 ns, release. Required: Data_BUS_READ=32'h1DAA, RD_VALID=0, counters 0. Read ADDR=0x10 → 32'h1DAA after 1 cycle, RD_VALID=1.
- Write/read, READ_LAT=1: write 0xDEADBEEF to 0x08, then read 0x08. Required: 0xDEADBEEF one cycle later; WR_COUNT=1, RD_COUNT=1.
- Pipelining, READ_LAT=3: preload 0x0,0x4,0x8 with 1,2,3; issue three consecutive reads. Required: RD_VALID high for 3 consecutive cycles starting 3 cycles after the first request, data 1,2,3 in order.
- OOR: DEPTH=256; write to 0x400, read from 0x402. Required: memory unchanged, read returns 32'h1DAA, OOR_ERR=1 and remains 1 until CLR_STATS; CLR_STATS together with a write to 0x0 → counters 0, and the word is still written.
- Saturation: 65537 reads. Required: RD_COUNT=16'hFFFF, no wrap.
- Reset mid-operation, READ_LAT=2: issue a read, assert RST=0 before the result appears. Required: RD_VALID never pulses. After release, a read of a previously written word returns 32'h1DAA because wvalid was cleared.
